// File: rtl/qos_grant_ctrl_pkg.sv
// arb_pkg: shared FSM state encoding and id-width helper for the stream arbiter.
package arb_pkg;
  typedef enum logic [1:0] {IDLE, CALC, SELECT, XFER} state_e;
  function automatic int id_width(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/qos_grant_ctrl_rr_pick.sv
// rr_pick: first set candidate at or above rr_ptr, wrapping modulo N.
module rr_pick #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] cand,
  input  logic [W-1:0] rr_ptr,
  output logic [W-1:0] gnt,
  output logic         found
);
  // Scan from the farthest offset down so the nearest hit wins.
  always_comb begin
    gnt = rr_ptr;
    for (int k = N - 1; k >= 0; k--)
      if (cand[(int'(rr_ptr) + k) % N]) gnt = W'((int'(rr_ptr) + k) % N);
    found = |cand;
  end
endmodule

// File: rtl/qos_grant_ctrl.sv
// qos_grant_ctrl: grants the max-QoS stream (round-robin on ties) and passes its packet to the master port.
module qos_grant_ctrl
  import arb_pkg::*;
#(
  parameter int T_DATA_WIDTH = 8,
  parameter int T_QOS__WIDTH = 4,
  parameter int STREAM_COUNT = 2,
  parameter int T_ID___WIDTH = id_width(STREAM_COUNT)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [T_DATA_WIDTH-1:0] s_data_i [STREAM_COUNT],
  input  logic [T_QOS__WIDTH-1:0] s_qos_i  [STREAM_COUNT],
  input  logic [STREAM_COUNT-1:0] s_last_i,
  input  logic [STREAM_COUNT-1:0] s_valid_i,
  output logic [STREAM_COUNT-1:0] s_ready_o,
  input  logic [T_QOS__WIDTH-1:0] max_qos,
  output logic                    can_calc,
  output logic [STREAM_COUNT-1:0] served,
  output logic [T_DATA_WIDTH-1:0] m_data_o,
  output logic [T_ID___WIDTH-1:0] m_id_o,
  output logic                    m_last_o,
  output logic                    m_valid_o,
  input  logic                    m_ready_i
);
  state_e                  state_q, state_d;
  logic [STREAM_COUNT-1:0] served_q, served_d, pending, cand;
  logic [T_ID___WIDTH-1:0] gnt_q, gnt_d, rr_q, rr_d, pick;
  logic [T_DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic                    m_last_q, m_last_d, found, xfer;

  assign xfer      = state_q == XFER;
  assign pending   = s_valid_i & ~served_q;
  assign can_calc  = state_q == CALC;
  assign served    = served_q;
  assign m_id_o    = gnt_q;
  assign m_valid_o = xfer & s_valid_i[gnt_q];
  assign m_data_o  = xfer ? s_data_i[gnt_q] : m_data_q;
  assign m_last_o  = xfer ? s_last_i[gnt_q] : m_last_q;
  assign m_data_d  = m_data_o;
  assign m_last_d  = m_last_o;

  always_comb begin
    cand = '0;
    for (int i = 0; i < STREAM_COUNT; i++)
      cand[i] = pending[i] & (s_qos_i[i] == max_qos);
  end

  rr_pick #(.N(STREAM_COUNT), .W(T_ID___WIDTH)) u_pick (
    .cand  (cand),
    .rr_ptr(rr_q),
    .gnt   (pick),
    .found (found)
  );

  always_comb begin
    state_d   = state_q;
    served_d  = served_q;
    gnt_d     = gnt_q;
    rr_d      = rr_q;
    s_ready_o = '0;
    case (state_q)
      IDLE:   if (|pending) state_d = CALC;
              else if (|(s_valid_i & served_q)) served_d = '0;
      CALC:   state_d = SELECT;
      SELECT: begin
        state_d = found ? XFER : IDLE;
        gnt_d   = found ? pick : gnt_q;
      end
      XFER: begin
        s_ready_o[gnt_q] = m_ready_i;
        if (m_valid_o && m_ready_i && s_last_i[gnt_q]) begin
          served_d[gnt_q] = 1'b1;
          rr_d    = (int'(gnt_q) == STREAM_COUNT - 1) ? '0 : gnt_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n)
    if (rst_n) begin
      state_q  <= IDLE;
      served_q <= '0;
      gnt_q    <= '0;
      rr_q     <= '0;
      m_data_q <= '0;
      m_last_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      served_q <= served_d;
      gnt_q    <= gnt_d;
      rr_q     <= rr_d;
      m_data_q <= m_data_d;
      m_last_q <= m_last_d;
    end
endmodule

// File: tb/tb_qos_grant_ctrl.sv
// tb_qos_grant_ctrl: directed bench with a behavioural QoS comparator and a beat scoreboard.
module tb_qos_grant_ctrl;
  logic       clk = 1'b0, rst_n = 1'b1, m_ready_i = 1'b0;
  logic [7:0] s_data_i [4] = '{default: 8'h0};
  logic [3:0] s_qos_i  [4] = '{default: 4'h0};
  logic [3:0] s_last_i = '0, s_valid_i = '0, s_ready_o, served, max_qos = '0, mx;
  logic       can_calc, m_last_o, m_valid_o;
  logic [7:0] m_data_o;
  logic [1:0] m_id_o;
  logic [8:0] src_q [4][$];
  logic [10:0] exp_q [$];
  logic [10:0] beat;
  logic [3:0] en = '1, hs_pend = '0;
  int checks = 0, failures = 0, lat;

  qos_grant_ctrl #(.T_DATA_WIDTH(8), .T_QOS__WIDTH(4), .STREAM_COUNT(4)) dut (
    .clk(clk), .rst_n(rst_n), .s_data_i(s_data_i), .s_qos_i(s_qos_i), .s_last_i(s_last_i),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .max_qos(max_qos), .can_calc(can_calc),
    .served(served), .m_data_o(m_data_o), .m_id_o(m_id_o), .m_last_o(m_last_o),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Comparator: registers the highest QoS among unserved valid streams.
  always @(posedge clk)
    if (can_calc) begin
      mx = '0;
      for (int i = 0; i < 4; i++)
        if (s_valid_i[i] && !served[i] && s_qos_i[i] > mx) mx = s_qos_i[i];
      max_qos <= mx;
    end

  always @(posedge clk) begin
    #2;
    for (int i = 0; i < 4; i++) begin
      if (hs_pend[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      s_valid_i[i] = en[i] && src_q[i].size() > 0;
      {s_last_i[i], s_data_i[i]} = src_q[i].size() > 0 ? src_q[i][0] : 9'h0;
    end
    hs_pend = '0;
  end

  always @(negedge clk) begin
    hs_pend = s_valid_i & s_ready_o;
    if (!rst_n && m_valid_o && m_ready_i) begin
      chk("sb_nonempty", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        beat = exp_q.pop_front();
        chk("beat", {21'b0, m_id_o, m_last_o, m_data_o}, {21'b0, beat});
      end
    end
  end

  task automatic load(input int id, input int n);
    for (int k = 0; k < n; k++) src_q[id].push_back({k == n - 1, 8'((id << 4) | k)});
  endtask

  task automatic expect_pkt(input int id, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back({2'(id), k == n - 1, 8'((id << 4) | k)});
  endtask

  task automatic flush();
    for (int i = 0; i < 4; i++) src_q[i].delete();
    exp_q.delete();
    en = '1;
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    flush();
    for (int i = 0; i < 4; i++) s_qos_i[i] = 4'h0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (n < 50) begin
      @(negedge clk);
      if (m_valid_o) break;
      n++;
    end
    chk(tag, m_valid_o, 1);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset while stream 2 holds a stalled grant.
    do_reset();
    s_qos_i[2] = 4'd5;
    load(2, 2);
    wait_valid("t1_valid");
    chk("t1_id", m_id_o, 2);
    chk("t1_data", m_data_o, 8'h20);
    chk("t1_sready_stall", s_ready_o, 0);
    #1 rst_n = 1'b1;
    #1;
    chk("t1_rst_valid", m_valid_o, 0);
    chk("t1_rst_data", m_data_o, 0);
    chk("t1_rst_id", m_id_o, 0);
    chk("t1_rst_last", m_last_o, 0);
    chk("t1_rst_served", served, 0);
    chk("t1_rst_sready", s_ready_o, 0);
    chk("t1_rst_calc", can_calc, 0);
    flush();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("t1_idle_calc", can_calc, 0);
    chk("t1_idle_valid", m_valid_o, 0);

    // Distinct QoS: descending-priority order, then a second round.
    do_reset();
    s_qos_i[0] = 4'd3; s_qos_i[1] = 4'd7; s_qos_i[2] = 4'd5; s_qos_i[3] = 4'd1;
    m_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) load(i, 1);
    expect_pkt(1, 1); expect_pkt(2, 1); expect_pkt(0, 1); expect_pkt(3, 1);
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      if (m_valid_o) break;
      lat++;
    end
    chk("t2_latency", lat, 3);
    drain("t2_drain1");
    chk("t2_served_full", served, 4'b1111);
    for (int i = 0; i < 4; i++) load(i, 1);
    expect_pkt(1, 1); expect_pkt(2, 1); expect_pkt(0, 1); expect_pkt(3, 1);
    @(posedge clk);
    @(negedge clk);
    chk("t2_served_clear", served, 0);
    drain("t2_drain2");
    chk("t2_served_full2", served, 4'b1111);

    // Tie between streams 0 and 3 with pointer wrap.
    do_reset();
    s_qos_i[0] = 4'd6; s_qos_i[3] = 4'd6;
    load(0, 1); load(3, 1);
    expect_pkt(0, 1); expect_pkt(3, 1);
    drain("t3_drain1");
    chk("t3_served", served, 4'b1001);
    load(0, 1); load(3, 1);
    expect_pkt(0, 1); expect_pkt(3, 1);
    drain("t3_drain2");
    chk("t3_served2", served, 4'b1001);

    // Four-beat packet with back-pressure on beats 2 and 3.
    do_reset();
    s_qos_i[1] = 4'd3;
    load(1, 4);
    expect_pkt(1, 4);
    wait_valid("t4_valid");
    chk("t4_served_b1", served, 0);
    for (int b = 1; b < 3; b++) begin
      @(posedge clk);
      #1 m_ready_i = 1'b0;
      repeat (2) begin
        @(negedge clk);
        chk("t4_hold_data", m_data_o, 8'(8'h10 | b));
        chk("t4_hold_sready", s_ready_o, 0);
        chk("t4_hold_valid", m_valid_o, 1);
        chk("t4_hold_served", served, 0);
      end
      @(posedge clk);
      #1 m_ready_i = 1'b1;
    end
    drain("t4_drain");
    chk("t4_served", served, 4'b0010);

    // Stream 2 drops valid while its grant is being selected.
    do_reset();
    s_qos_i[2] = 4'd4;
    load(2, 1);
    @(posedge clk);
    @(negedge clk);
    chk("t5_calc", can_calc, 1);
    @(posedge clk);
    #1 en[2] = 1'b0;
    lat = 0;
    repeat (6) begin
      @(negedge clk);
      if (m_valid_o) lat++;
    end
    chk("t5_no_valid", lat, 0);
    chk("t5_served", served, 0);
    chk("t5_idle", can_calc, 0);
    flush();

    // QoS 0 streams still compete.
    do_reset();
    load(0, 1); load(2, 1);
    expect_pkt(0, 1); expect_pkt(2, 1);
    drain("t6_drain");
    chk("t6_served", served, 4'b0101);

    chk("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
